mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the cache/main-memory valid/ready interface. It is the target that a cache_wrapper-style initiator talks to.
// - Accepts one word read/write at a time and inserts a configurable number of wait states.
// - Stores data in word-addressed SRAM and returns read data in the same cycle as ready.
// - Used as the SoC main-memory front end and as the memory model in cache benches.
// PARAMETERS
// - DATA_WIDTH  32     word width
// - ADDR_WIDTH  16     word address width
// - MEM_DEPTH   65536  implemented words; must be <= 2**ADDR_WIDTH
// - LATENCY     2      wait cycles between accept and ready, 0..15
// - OOR_DATA    32'hDEADBEEF  read data returned for out-of-range addresses
// PORTS
// - clk_i        in   1           clock
// - rst_i        in   1           reset, synchronous, active-high
// - mem_valid_i  in   1           request valid; initiator holds it until ready
// - mem_ready_o  out  1           one-cycle completion pulse
// - mem_we_i     in   1           1 = write, 0 = read
// - mem_adr_i    in   ADDR_WIDTH  word address
// - mem_wdata_i  in   DATA_WIDTH  write data
// - mem_rdata_o  out  DATA_WIDTH  read data; meaningful only while mem_ready_o = 1
// - oor_o        out  1           pulses together with mem_ready_o when the address is >= MEM_DEPTH
// - err_o        out  1           sticky protocol-error flag
// - rd_cnt_o     out  16          completed reads; saturates at 16'hFFFF
// - wr_cnt_o     out  16          completed writes; saturates at 16'hFFFF
// BEHAVIOUR
// - One clock, clk_i. Reset rst_i is synchronous and active-high.
// - Reset values:
//   - state = IDLE
//   - mem_ready_o, oor_o and err_o = 0
//   - mem_rdata_o = 0
//   - both counters = 0
//   - SRAM contents are not cleared.
// - FSM IDLE -> WAIT -> RESP -> IDLE:
//   - IDLE: if mem_valid_i is high, accept the request in cycle T.
//     - Capture adr, we and wdata.
//     - Load wait counter = LATENCY.
//     - Go to WAIT, or go straight to RESP if LATENCY = 0.
//   - WAIT: decrement the counter each cycle; go to RESP on the cycle it would reach 0.
//   - RESP: drive mem_ready_o = 1 for exactly one cycle, then return to IDLE.
// - Timing:
//   - mem_ready_o asserts at cycle T+1+LATENCY.
//   - Minimum request spacing is LATENCY+2 cycles, because IDLE always costs one cycle.
// - Captured request fields are authoritative. Changes on mem_adr_i, mem_we_i or mem_wdata_i after accept are ignored.
// - SRAM access (prim_ram, 1-cycle synchronous read):
//   - Address = mem_adr_i while in IDLE, otherwise the captured address.
//   - en is held at 1.
//   - The read data is therefore valid in the RESP cycle for every LATENCY, including 0.
// - Reads:
//   - In RESP, mem_rdata_o = SRAM data, or OOR_DATA if out of range.
//   - Outside RESP, and on write responses, mem_rdata_o = 0.
// - Writes:
//   - The SRAM we is asserted only in the RESP cycle, using the captured address and data.
//   - Out-of-range writes are dropped and pulse oor_o.
//   - A read of the same address that is accepted right after a write's RESP sees the new data.
// - Counters: rd_cnt_o / wr_cnt_o increment in RESP, including for out-of-range requests, and saturate.
// - err_o is set if mem_valid_i is low during WAIT or RESP.
//   - The transaction still completes normally.
//   - err_o is cleared only by reset.
// - Reset during WAIT aborts the request. No write is committed and no ready pulse is issued.
// - Reset in the RESP cycle suppresses the write, because reset takes priority over we.
// STRUCTURE
// - Package mem_responder_pkg:
//   - state_t enum {IDLE, WAIT, RESP}
//   - LAT_W = 4
//   - CNT_W = 16
// - Storage: one prim_ram instance, MEM_DEPTH x DATA_WIDTH, with rst_ni tied to !rst_i.
// - The FSM, capture registers, counters and flags all live in mem_responder. No other sub-module.
// TESTING
// - 1. LATENCY=2: write 0x0010 <= 0xCAFEF00D, accepted at T.
//   - ready at T+3, one cycle wide.
//   - Then read 0x0010 -> mem_rdata_o = 0xCAFEF00D in its ready cycle.
//   - wr_cnt_o = 1, rd_cnt_o = 1.
// - 2. Cache-style writeback then refill, mem_valid_i held high throughout.
//   - Sequence: write 0x0100 <= 0x11, then read 0x0200, which was preloaded with 0x12345678.
//   - Ready pulses at T+3 and T+7; the read returns 0x12345678.
// - 3. LATENCY=0: read accepted at T -> ready and correct data at T+1.
// - 4. MEM_DEPTH=1024:
//   - read 0x0400 -> mem_rdata_o = 0xDEADBEEF, oor_o = 1.
//   - write 0x0400 -> oor_o = 1, with no SRAM change.
// - 5. Reset asserted in WAIT of a write 0x0020 <= 0xAAAA5555, with 0x0020 preloaded to 0x1:
//   - no ready pulse, all outputs return to reset values.
//   - a later read of 0x0020 returns 0x1.
// - 6. mem_valid_i dropped for one cycle in WAIT, with mem_adr_i changed:
//   - err_o = 1 and stays 1.
//   - ready is still issued, and the response uses the originally captured address.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
//   state_t : FSM encoding (IDLE / WAIT / RESP)
//   LAT_W   : width of the wait-state counter (LATENCY 0..15)
//   CNT_W   : width of the completed-read / completed-write counters
//   sat_inc : saturating increment used by the transaction counters
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LAT_W = 4;
  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/prim_ram.sv
// Single-port word-addressed SRAM with a 1-cycle synchronous read.
//   clk_i   : clock
//   rst_ni  : active-low synchronous reset of the read-data register only
//   en_i    : access enable (read and write)
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (old contents on a same-address write)
// The array itself is never cleared.
module prim_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (en_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a valid/ready word interface. Accepts one
// read or write at a time, inserts LATENCY wait states, then pulses
// mem_ready_o for one cycle. Reads return SRAM data (or OOR_DATA for
// addresses >= MEM_DEPTH) in the ready cycle.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   mem_valid_i  : request valid, held by the initiator until ready
//   mem_ready_o  : one-cycle completion pulse
//   mem_we_i     : 1 = write, 0 = read
//   mem_adr_i    : word address
//   mem_wdata_i  : write data
//   mem_rdata_o  : read data, non-zero only in a read's ready cycle
//   oor_o        : out-of-range flag, pulses with mem_ready_o
//   err_o        : sticky protocol error (valid dropped mid-transaction)
//   rd_cnt_o     : saturating count of completed reads
//   wr_cnt_o     : saturating count of completed writes
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for mem_valid_i; SRAM addressed by the live bus
// WAIT  | counting down wait states; SRAM addressed by captured address
// RESP  | ready pulse, read data out, write committed to SRAM
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    MEM_DEPTH  = 65536,
  parameter int                    LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] OOR_DATA   = 32'hDEADBEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_adr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  oor_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      wr_cnt_o
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  err_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic [CNT_W-1:0]      wr_cnt_q;

  logic                  accept;
  logic                  oor_q;
  logic                  ram_we;
  logic                  rst_n;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept = (state_q == IDLE) && mem_valid_i;
  assign oor_q  = ({1'b0, adr_q} >= DEPTH_LIM);
  assign rst_n  = !rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture registers, wait counter, error flag and transaction counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q    <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      lat_q    <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (accept) begin
        adr_q   <= mem_adr_i;
        wdata_q <= mem_wdata_i;
        we_q    <= mem_we_i;
        lat_q   <= LAT_W'(LATENCY);
      end else if (state_q == WAIT) begin
        lat_q <= lat_q - LAT_W'(1);
      end

      if (((state_q == WAIT) || (state_q == RESP)) && !mem_valid_i) begin
        err_q <= 1'b1;
      end

      if (state_q == RESP) begin
        if (we_q) begin
          wr_cnt_q <= sat_inc(wr_cnt_q);
        end else begin
          rd_cnt_q <= sat_inc(rd_cnt_q);
        end
      end
    end
  end

  // Output logic
  always_comb begin
    mem_ready_o = (state_q == RESP);
    oor_o       = (state_q == RESP) && oor_q;
    mem_rdata_o = '0;
    if ((state_q == RESP) && !we_q) begin
      mem_rdata_o = oor_q ? OOR_DATA : ram_rdata;
    end
    // Reset wins over a write landing in the RESP cycle.
    ram_we   = (state_q == RESP) && we_q && !oor_q && !rst_i;
    // Live address in IDLE so the read is launched on the accept edge;
    // this makes data ready in RESP even with zero wait states.
    ram_addr = (state_q == IDLE) ? mem_adr_i[RAM_AW-1:0] : adr_q[RAM_AW-1:0];
  end

  assign err_o    = err_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

  prim_ram #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_n),
    .en_i    (1'b1),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule
